mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Purpose : byte/half/word load-store adapter between a pipeline and a 32-bit single-port word RAM.
// Latency : loads, SW and errors respond 1 cycle after accept; SB/SH read-modify-write responds after 3.
// Backpress: busy holds while an op is in flight; requests presented while busy are ignored, not queued.
//
// Ports
//   clk, reset                    : clock and synchronous active-high reset
//   req_valid/req_we/funct/addr/wdata : request (accepted in IDLE only)
//   busy                          : op in flight, upstream must stall
//   resp_valid/resp_data/resp_err : one-cycle completion pulse with load result / error flag
//   mem_re/mem_we/mem_addr/mem_wdata/mem_rdata : word RAM port, read data returns one cycle after mem_re
module mem_access_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        funct,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LD_WAIT = 3'd1,
    RMW_RD  = 3'd2,
    RMW_WR  = 3'd3,
    ACK     = 3'd4
  } state_t;

  state_t state_q, state_d;

  // Latched request. Only the address bits that reach the RAM or select a
  // lane are kept; sub-word stores only ever need the low half of wdata
  // because SW writes straight through in the accept cycle.
  logic              we_q;
  logic [2:0]        funct_q;
  logic [ADDR_W+1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              err_q;
  logic [31:0]       merge_q;

  logic              accept;
  logic              req_err;
  logic              req_is_sw;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_result;
  logic [31:0]       merged;

  // Byte-address bits above the RAM window are deliberately ignored.
  logic              unused_addr_hi;
  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  assign accept    = (state_q == IDLE) && req_valid;
  assign req_is_sw = req_we && (funct == 3'b010);
  assign busy      = (state_q != IDLE);

  // Request legality: reserved funct codes and misaligned half/word accesses.
  always_comb begin
    req_err = 1'b0;
    case (funct)
      3'b000:         req_err = 1'b0;
      3'b001:         req_err = addr[0];
      3'b010:         req_err = |addr[1:0];
      3'b100, 3'b101: req_err = req_we ? 1'b1 : (funct[0] & addr[0]);
      default:        req_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = ACK;
          end else if (!req_we) begin
            state_d = LD_WAIT;
          end else if (req_is_sw) begin
            state_d = ACK;
          end else begin
            state_d = RMW_RD;
          end
        end
      end
      LD_WAIT: state_d = IDLE;
      RMW_RD:  state_d = RMW_WR;
      RMW_WR:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Request latch and read-modify-write merge register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      funct_q <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      err_q   <= 1'b0;
      merge_q <= 32'h0000_0000;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        funct_q <= funct;
        addr_q  <= addr[ADDR_W+1:0];
        wdata_q <= wdata[15:0];
        err_q   <= req_err;
      end
      // The RAM word read in the accept cycle is valid now.
      if (state_q == RMW_RD) begin
        merge_q <= mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Load alignment and extension (mem_rdata is valid in LD_WAIT)
  // ---------------------------------------------------------------------
  always_comb begin
    case (addr_q[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // funct[2] selects zero extension (LBU/LHU); funct[1:0] selects size.
    case (funct_q[1:0])
      2'b00:   ld_result = {{24{ld_byte[7] & ~funct_q[2]}}, ld_byte};
      2'b01:   ld_result = {{16{ld_half[15] & ~funct_q[2]}}, ld_half};
      default: ld_result = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------
  // Store merge: insert the new byte/half into the captured word
  // ---------------------------------------------------------------------
  always_comb begin
    merged = merge_q;
    if (funct_q[0]) begin
      if (addr_q[1]) begin
        merged[31:16] = wdata_q;
      end else begin
        merged[15:0] = wdata_q;
      end
    end else begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = 32'h0000_0000;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = 32'h0000_0000;
    // Address follows the live request while idle so the RAM can be
    // started in the accept cycle.
    mem_addr   = (state_q == IDLE) ? addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];

    // Reset masks every strobe so an aborted op never writes or responds.
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (req_valid && !req_err) begin
            if (req_is_sw) begin
              mem_we    = 1'b1;
              mem_wdata = wdata;
            end else begin
              // Loads, and the read half of SB/SH.
              mem_re = 1'b1;
            end
          end
        end
        LD_WAIT: begin
          resp_valid = 1'b1;
          resp_data  = we_q ? 32'h0000_0000 : ld_result;
        end
        RMW_WR: begin
          mem_we    = 1'b1;
          mem_wdata = merged;
        end
        ACK: begin
          resp_valid = 1'b1;
          resp_err   = err_q;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
  localparam int ADDR_W = 10;
  localparam int NWORDS = 1 << ADDR_W;
  localparam int K_LOAD = 0;
  localparam int K_SW   = 1;
  localparam int K_RMW  = 2;
  localparam int K_ERR  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_we;
  logic [2:0]        funct;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              resp_valid;
  logic [31:0]       resp_data;
  logic              resp_err;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              ram_init;
  logic [31:0]       ram     [NWORDS];
  logic [31:0]       ref_mem [NWORDS];
  bit                model_en = 1'b0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .funct      (funct),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'h8765_43A1;
    return 32'h9E37_79B9 * 32'(i + 1);
  endfunction

  // Word RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < NWORDS; i++) ram[i] <= init_word(i);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference rules ----------------
  function automatic bit op_illegal(logic we, logic [2:0] f, logic [31:0] a);
    int  size  = int'(f[1:0]);
    bit  legal = we ? (f <= 3'd2) : ((f[1:0] != 2'd3) && (f <= 3'd5));
    if (!legal) return 1'b1;
    return (a % (32'd1 << size)) != 32'd0;
  endfunction

  function automatic logic [31:0] load_val(logic [2:0] f, logic [1:0] off, logic [31:0] w);
    logic [31:0] b = (w >> (8 * int'(off))) & 32'hFF;
    logic [31:0] h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 32'h80)   ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge_val(logic [2:0] f, logic [1:0] off, logic [31:0] w, logic [31:0] d);
    logic [31:0] mask;
    logic [31:0] ins;
    if (f == 3'd0) begin
      mask = 32'hFF << (8 * int'(off));
      ins  = (d & 32'hFF) << (8 * int'(off));
    end else begin
      mask = 32'hFFFF << (16 * int'(off[1]));
      ins  = (d & 32'hFFFF) << (16 * int'(off[1]));
    end
    return (w & ~mask) | ins;
  endfunction

  // ---------------- transaction model + per-cycle compare ----------------
  int                left = 0;
  int                kind = K_LOAD;
  logic [31:0]       m_data = 32'h0;
  logic [ADDR_W-1:0] m_waddr = '0;
  logic [31:0]       m_wword = 32'h0;
  bit                prev_reset = 1'b0;

  always @(negedge clk) begin : model_p
    bit          acc;
    bit          e;
    bit          x_re;
    bit          x_we;
    bit          x_rv;
    logic [31:0] cur;
    if (ram_init) begin
      for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);
    end
    if (model_en) begin
      acc  = (left == 0) && req_valid && !reset;
      e    = acc && op_illegal(req_we, funct, addr);
      x_re = acc && !e && !(req_we && funct == 3'd2);
      x_we = (acc && !e && req_we && funct == 3'd2) ||
             (!reset && kind == K_RMW && left == 2);
      x_rv = !reset && left == 1;

      chk("busy", {31'b0, busy}, {31'b0, left > 0});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, x_rv});
      chk("mem_re", {31'b0, mem_re}, {31'b0, x_re});
      chk("mem_we", {31'b0, mem_we}, {31'b0, x_we});
      if (x_re || x_we)
        chk("mem_addr", 32'(mem_addr), acc ? 32'(addr[ADDR_W+1:2]) : 32'(m_waddr));
      if (x_we)
        chk("mem_wdata", mem_wdata, acc ? wdata : m_wword);
      if (x_rv) begin
        chk("resp_err", {31'b0, resp_err}, {31'b0, kind == K_ERR});
        chk("resp_data", resp_data, m_data);
      end else begin
        chk("resp_data_idle", resp_data, 32'h0);
      end
      if (reset && prev_reset) chk("mem_wdata_rst", mem_wdata, 32'h0);

      if (reset) begin
        left = 0;
      end else if (acc) begin
        m_waddr = addr[ADDR_W+1:2];
        cur     = ref_mem[m_waddr];
        m_data  = 32'h0;
        if (e) begin
          kind = K_ERR;
          left = 1;
        end else if (!req_we) begin
          kind   = K_LOAD;
          left   = 1;
          m_data = load_val(funct, addr[1:0], cur);
        end else if (funct == 3'd2) begin
          kind = K_SW;
          left = 1;
          ref_mem[m_waddr] = wdata;
        end else begin
          kind    = K_RMW;
          left    = 3;
          m_wword = merge_val(funct, addr[1:0], cur, wdata);
        end
      end else if (left > 0) begin
        if (kind == K_RMW && left == 2) ref_mem[m_waddr] = m_wword;
        left--;
      end
    end
    prev_reset = reset;
  end

  // ---------------- stimulus ----------------
  // Presents a request for exactly one cycle; returns 1ns into the next cycle.
  task automatic issue(input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    funct     = f;
    addr      = a;
    wdata     = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; ram_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; funct = 3'd0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    model_en  = 1'b1;
    // Reset must dominate a valid SW request.
    req_valid = 1'b1; req_we = 1'b1; funct = 3'd2; addr = 32'h40; wdata = 32'hDEAD_BEEF;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_mem_re", {31'b0, mem_re}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; ram_init = 1'b0; req_valid = 1'b0;
    idle(1);

    // Loads from word 0x40 = 0x8765_43A1.
    issue(1'b0, 3'd0, 32'h41, 32'h0); #1;
    chk("lb41_valid", {31'b0, resp_valid}, 32'h1);
    chk("lb41_data", resp_data, 32'h0000_0043);
    idle(1);
    issue(1'b0, 3'd0, 32'h40, 32'h0); #1;
    chk("lb40_data", resp_data, 32'hFFFF_FFA1);
    idle(1);
    issue(1'b0, 3'd5, 32'h42, 32'h0); #1;
    chk("lhu42_data", resp_data, 32'h0000_8765);
    idle(1);

    // SB into a known word via RMW.
    issue(1'b1, 3'd2, 32'h40, 32'h1122_3344); #1;
    chk("sw40_valid", {31'b0, resp_valid}, 32'h1);
    idle(1);
    issue(1'b1, 3'd0, 32'h42, 32'hFFFF_FFAB); #1;
    chk("sb_t1_we", {31'b0, mem_we}, 32'h0);
    idle(1); #1;
    chk("sb_t2_we", {31'b0, mem_we}, 32'h1);
    chk("sb_t2_wdata", mem_wdata, 32'h11AB_3344);
    chk("sb_t2_addr", 32'(mem_addr), 32'h10);
    idle(1); #1;
    chk("sb_t3_valid", {31'b0, resp_valid}, 32'h1);
    idle(1);
    issue(1'b0, 3'd2, 32'h40, 32'h0); #1;
    chk("lw40_data", resp_data, 32'h11AB_3344);
    idle(1);

    // Error cases.
    issue(1'b1, 3'd2, 32'h46, 32'h1234_5678); #1;
    chk("sw46_err", {31'b0, resp_err}, 32'h1);
    idle(1);
    issue(1'b0, 3'd1, 32'h41, 32'h0); #1;
    chk("lh41_err", {31'b0, resp_err}, 32'h1);
    idle(1);
    issue(1'b0, 3'd7, 32'h40, 32'h0); #1;
    chk("ld111_err", {31'b0, resp_err}, 32'h1);
    idle(1);

    // req_valid held high: LW then SW, second accepted at T+2.
    req_valid = 1'b1; req_we = 1'b0; funct = 3'd2; addr = 32'h40; wdata = 32'h0;
    @(posedge clk); #1;
    req_we = 1'b1; addr = 32'h48; wdata = 32'hCAFE_F00D; #1;
    chk("b2b_t1_re", {31'b0, mem_re}, 32'h0);
    chk("b2b_t1_we", {31'b0, mem_we}, 32'h0);
    chk("b2b_t1_data", resp_data, 32'h11AB_3344);
    @(posedge clk); #2;
    chk("b2b_t2_we", {31'b0, mem_we}, 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0; #1;
    chk("b2b_t3_valid", {31'b0, resp_valid}, 32'h1);
    idle(1);

    // SH aborted by reset while in RMW_RD.
    issue(1'b1, 3'd1, 32'h44, 32'h0000_5555);
    reset = 1'b1; #1;
    chk("abort_busy_before", {31'b0, busy}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b0; #1;
    chk("abort_busy_after", {31'b0, busy}, 32'h0);
    idle(3);
    issue(1'b0, 3'd2, 32'h44, 32'h0); #1;
    chk("abort_word", resp_data, init_word(17));
    idle(1);

    // Randomised traffic, including requests while busy and rare resets.
    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 299) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      funct     = 3'($urandom_range(0, 7));
      addr      = {24'h0, 8'($urandom)};
      if ($urandom_range(0, 1) == 0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) addr = addr | ($urandom & 32'hFFFF_FF00);
      wdata     = $urandom;
      @(posedge clk); #1;
    end
    reset = 1'b0; req_valid = 1'b0;
    idle(6);
    for (int i = 0; i < 64; i++) chk("ram_final", ram[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
